// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - word-addressed data RAM responder with configurable wait states
// Stalls the core while an access is in flight and flags illegal requests.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] MemoryAddress,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        stall,
  output logic        done,
  output logic        err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        rd_q, wr_q;
  logic [31:0] addr_q, wdata_q;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic        enter_resp;
  logic        capture;
  logic        mem_we;

  logic [31:0] mem [DEPTH_WORDS];

  logic          sel_rd, sel_wr, sel_bad;
  logic [31:0]   sel_addr, sel_wdata;
  logic [AW-1:0] sel_idx;

  // In IDLE the live inputs are the request; after acceptance only the captured copy counts.
  always_comb begin
    sel_rd    = rd_q;
    sel_wr    = wr_q;
    sel_addr  = addr_q;
    sel_wdata = wdata_q;
    if (state_q == IDLE) begin
      sel_rd    = MemRead;
      sel_wr    = MemWrite;
      sel_addr  = MemoryAddress;
      sel_wdata = WriteData;
    end
    sel_idx = sel_addr[AW+1:2];
    sel_bad = (sel_rd & sel_wr) | (sel_addr[1:0] != 2'b00) | (sel_addr[31:AW+2] != '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stall      = 1'b0;
    enter_resp = 1'b0;
    capture    = 1'b0;
    case (state_q)
      IDLE: begin
        if (rst && (MemRead || MemWrite)) begin
          stall   = 1'b1;
          capture = 1'b1;
          if (LATENCY == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (cnt_q == 4'd0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
    end else if (capture) begin
      rd_q    <= MemRead;
      wr_q    <= MemWrite;
      addr_q  <= MemoryAddress;
      wdata_q <= WriteData;
    end
  end

  always_comb begin
    err_d   = err_q;
    rdata_d = rdata_q;
    if (enter_resp) begin
      err_d = sel_bad;
      if (sel_bad) begin
        rdata_d = 32'd0;
      end else if (sel_rd) begin
        rdata_d = mem[sel_idx];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Gated by rst so a write whose RESP edge coincides with reset is never committed.
  assign mem_we = enter_resp & rst & sel_wr & ~sel_bad;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[sel_idx] <= sel_wdata;
    end
  end

  assign ReadData = rdata_q;
  assign done     = (state_q == RESP);
  assign err      = (state_q == RESP) & err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder at LATENCY 2 and LATENCY 0
module tb_dmem_responder;

  logic        clk, rst;
  logic        rd0, wr0, rd1, wr1;
  logic [31:0] a0, d0, a1, d1;
  logic [31:0] rdata0, rdata1;
  logic        stall0, stall1, done0, done1, err0, err1;

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] last_rd[2];

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u_dut0 (
    .clk(clk), .rst(rst), .MemRead(rd0), .MemWrite(wr0), .MemoryAddress(a0), .WriteData(d0),
    .ReadData(rdata0), .stall(stall0), .done(done0), .err(err0)
  );

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(0)) u_dut1 (
    .clk(clk), .rst(rst), .MemRead(rd1), .MemWrite(wr1), .MemoryAddress(a1), .WriteData(d1),
    .ReadData(rdata1), .stall(stall1), .done(done1), .err(err1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_resp(input int sel, input exp_t e, input logic [31:0] rdata, input logic e_out);
    chk($sformatf("dut%0d ReadData", sel), rdata, e.data);
    chk($sformatf("dut%0d err", sel), {31'd0, e_out}, {31'd0, e.err});
    chk($sformatf("dut%0d done cycle", sel), cyc, e.cyc);
  endtask

  always @(negedge clk) begin
    if (done0) begin
      if (q0.size() == 0) chk("dut0 unexpected done", 32'd1, 32'd0);
      else check_resp(0, q0.pop_front(), rdata0, err0);
    end
    if (done1) begin
      if (q1.size() == 0) chk("dut1 unexpected done", 32'd1, 32'd0);
      else check_resp(1, q1.pop_front(), rdata1, err1);
    end
  end

  task automatic drive(input int sel, input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata);
    if (sel == 0) begin
      rd0 = rd; wr0 = wr; a0 = addr; d0 = wdata;
    end else begin
      rd1 = rd; wr1 = wr; a1 = addr; d1 = wdata;
    end
  endtask

  task automatic access(input int sel, input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic exp_err, input logic [31:0] exp_rd,
                        input logic use_alt, input logic [31:0] alt_addr);
    exp_t e;
    bit   got;
    int   lat;
    lat = (sel == 0) ? 2 : 0;
    got = 0;
    @(posedge clk);
    #1;
    drive(sel, rd, wr, addr, wdata);
    e.data = exp_err ? 32'd0 : (rd ? exp_rd : last_rd[sel]);
    e.err  = exp_err;
    e.cyc  = cyc + lat + 1;
    last_rd[sel] = e.data;
    if (sel == 0) q0.push_back(e);
    else q1.push_back(e);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ((sel == 0) ? done0 : done1) begin
        got = 1;
        break;
      end
      chk($sformatf("dut%0d stall during access", sel), {31'd0, (sel == 0) ? stall0 : stall1}, 32'd1);
      if (use_alt && i == 1) a0 = alt_addr;
    end
    if (!got) chk($sformatf("dut%0d done timeout", sel), 32'd0, 32'd1);
    else chk($sformatf("dut%0d stall at done", sel), {31'd0, (sel == 0) ? stall0 : stall1}, 32'd0);
    drive(sel, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
    last_rd[0] = 32'd0;
    last_rd[1] = 32'd0;

    // Reset state: a request presented during reset is not recognised.
    #3 rd0 = 1'b1;
    #1;
    chk("reset stall", {31'd0, stall0}, 32'd0);
    chk("reset ReadData", rdata0, 32'd0);
    chk("reset done", {31'd0, done0}, 32'd0);
    chk("reset err", {31'd0, err0}, 32'd0);
    rd0 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("idle stall", {31'd0, stall0}, 32'd0);

    // Write then read, latency 2
    access(0, 0, 1, 32'h10, 32'hDEADBEEF, 0, 32'h0, 0, 32'h0);
    access(0, 1, 0, 32'h10, 32'h0, 0, 32'hDEADBEEF, 0, 32'h0);

    // Latency 0 instance
    access(1, 0, 1, 32'h4, 32'h12345678, 0, 32'h0, 0, 32'h0);
    access(1, 1, 0, 32'h4, 32'h0, 0, 32'h12345678, 0, 32'h0);
    access(1, 1, 0, 32'h6, 32'h0, 1, 32'h0, 0, 32'h0);

    // Misaligned store has no effect
    access(0, 0, 1, 32'h11, 32'hFFFFFFFF, 1, 32'h0, 0, 32'h0);
    access(0, 1, 0, 32'h10, 32'h0, 0, 32'hDEADBEEF, 0, 32'h0);

    // Illegal: both ops, out of range (no alias into word 0)
    access(0, 1, 1, 32'h20, 32'h0, 1, 32'h0, 0, 32'h0);
    access(0, 0, 1, 32'h0, 32'h11111111, 0, 32'h0, 0, 32'h0);
    access(0, 0, 1, 32'h400, 32'hCAFEF00D, 1, 32'h0, 0, 32'h0);
    access(0, 1, 0, 32'h400, 32'h0, 1, 32'h0, 0, 32'h0);
    access(0, 1, 0, 32'h0, 32'h0, 0, 32'h11111111, 0, 32'h0);

    // Abort: reset during WAIT of a store leaves the word unchanged
    access(0, 0, 1, 32'h30, 32'hA5A5A5A5, 0, 32'h0, 0, 32'h0);
    access(0, 1, 0, 32'h10, 32'h0, 0, 32'hDEADBEEF, 0, 32'h0);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 1'b1, 32'h30, 32'h5A5A5A5A);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("abort ReadData", rdata0, 32'd0);
    chk("abort stall", {31'd0, stall0}, 32'd0);
    chk("abort done", {31'd0, done0}, 32'd0);
    chk("abort err", {31'd0, err0}, 32'd0);
    chk("abort dut1 ReadData", rdata1, 32'd0);
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    last_rd[0] = 32'd0;
    last_rd[1] = 32'd0;
    @(negedge clk);
    rst = 1'b1;
    access(0, 1, 0, 32'h30, 32'h0, 0, 32'hA5A5A5A5, 0, 32'h0);

    // Address change during WAIT is ignored
    access(0, 1, 0, 32'h10, 32'h0, 0, 32'hDEADBEEF, 1, 32'h30);

    repeat (3) @(negedge clk);
    chk("dut0 pending responses", q0.size(), 32'd0);
    chk("dut1 pending responses", q1.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
